// File: rtl/contador_display_n_pkg.sv
// Shared types and helpers for the up/down counter with sequential BCD display path.
package contador_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } conv_state_e;

    // Smallest number of decimal digits able to show every value up to top.
    function automatic int unsigned min_digits(longint unsigned top);
        int unsigned     d;
        longint unsigned p;
        d = 1;
        p = 10;
        while (p <= top) begin
            d++;
            p = p * 10;
        end
        return d;
    endfunction

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic bcd_digit_t dabble(bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/contador_display_n_if.sv
// Control and display bundle between the board-side driver and contador_display_n.
interface contador_display_n_if #(
    parameter int unsigned N      = 6,
    parameter int unsigned DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [N-1:0]          load_val;
    logic [N-1:0]          count;
    logic                  tc;
    logic                  busy;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output en, up, load, load_val,
        input  count, tc, busy, seg
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, busy, seg
    );
endinterface

// File: rtl/contador_display_n_bin2bcd_seq.sv
// Multi-cycle shift-add-3 binary to BCD converter: one bit per cycle, N+2 cycles per value.
module bin2bcd_seq
    import contador_pkg::*;
#(
    parameter int unsigned N      = 6,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          bin,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);
    localparam int unsigned AW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(N + 1);

    conv_state_e   state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [AW-1:0] acc_q, acc_d, acc_adj;
    logic [CW-1:0] bits_q, bits_d;

    always_comb begin
        acc_adj = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            acc_adj[4*k +: 4] = dabble(acc_q[4*k +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        bits_d  = bits_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d = bin;
                    acc_d   = '0;
                    bits_d  = CW'(N);
                    state_d = StShift;
                end
            end
            StShift: begin
                acc_d   = {acc_adj[AW-2:0], shreg_q[N-1]};
                shreg_d = shreg_q << 1;
                bits_d  = bits_q - CW'(1);
                if (bits_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            acc_q   <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            bits_q  <= bits_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign bcd  = acc_q;
endmodule

// File: rtl/display_hex.sv
// Hex nibble to active-low seven-segment pattern; bit 0 is segment a, bit 6 is segment g.
module display_hex (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/contador_display_n.sv
// Prescaled up/down modulo counter with load and wrap pulse, shown in decimal on DIGITS
// seven-segment displays via a sequential BCD converter.
module contador_display_n
    import contador_pkg::*;
#(
    parameter int unsigned N        = 6,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TOP      = (32'd1 << N) - 32'd1,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    contador_display_n_if.slave   bus
);
    if ((TOP < 1) || (longint'(TOP) > ((64'd1 << N) - 64'd1)) || (PRESCALE < 1) ||
        (DIGITS < min_digits(longint'(TOP)))) begin : g_param_check
        $error("contador_display_n: illegal TOP/PRESCALE/DIGITS combination");
    end

    localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N-1:0]   TopVal  = N'(TOP);
    localparam logic [PW-1:0]  PreLast = PW'(PRESCALE - 1);

    logic [N-1:0]          count_q, count_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  tc_q, tc_d;
    logic                  step;
    logic [N-1:0]          snap_q;
    logic [4*DIGITS-1:0]   digits_q;
    logic                  conv_start, conv_busy, conv_done;
    logic [4*DIGITS-1:0]   conv_bcd;
    logic [7*DIGITS-1:0]   seg_w;

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        tc_d    = 1'b0;
        step    = bus.en && (presc_q == PreLast);
        if (bus.load) begin
            count_d = (bus.load_val > TopVal) ? TopVal : bus.load_val;
            presc_d = '0;
        end else if (step) begin
            presc_d = '0;
            if (bus.up) begin
                if (count_q == TopVal) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + N'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = TopVal;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - N'(1);
                end
            end
        end else if (bus.en) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Changes while a conversion runs are picked up by the mismatch once the converter idles.
    assign conv_start = !conv_busy && (count_q != snap_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= TopVal;
            presc_q  <= '0;
            tc_q     <= 1'b0;
            snap_q   <= '0;
            digits_q <= '0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            if (conv_start) begin
                snap_q <= count_q;
            end
            if (conv_done) begin
                digits_q <= conv_bcd;
            end
        end
    end

    bin2bcd_seq #(
        .N      (N),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (count_q),
        .busy  (conv_busy),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
        display_hex u_hex (
            .hex (digits_q[4*k +: 4]),
            .seg (seg_w[7*k +: 7])
        );
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = conv_busy;
    assign bus.seg   = seg_w;
endmodule

// File: tb/tb_contador_display_n.sv
// Bench for contador_display_n: three configurations, vector table, directed corners, random run.
module tb_contador_display_n;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    contador_display_n_if #(.N(6), .DIGITS(2)) if_a ();
    contador_display_n_if #(.N(6), .DIGITS(2)) if_b ();
    contador_display_n_if #(.N(8), .DIGITS(3)) if_c ();

    contador_display_n #(.N(6), .DIGITS(2), .TOP(63), .PRESCALE(1)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    contador_display_n #(.N(6), .DIGITS(2), .TOP(59), .PRESCALE(10)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );
    contador_display_n #(.N(8), .DIGITS(3), .TOP(255), .PRESCALE(1)) dut_c (
        .clk (clk), .rst (rst), .bus (if_c.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       load;
        logic [5:0] lv;
        logic       en;
        logic       up;
        int         exp_count;
        logic       exp_tc;
    } vec_t;
    vec_t vec[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg7(int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] seg_exp(int unsigned v, int unsigned nd);
        logic [20:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < int'(nd); k++) begin
            r[7*k +: 7] = seg7(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    int   busy_cnt;
    int   m_count, m_presc, exp_cnt;
    logic m_tc, found;
    int   hist[$];
    logic ld, en, up;
    int   lv;

    initial begin
        vec[0]  = '{1'b1, 6'd1,  1'b0, 1'b0, 1,  1'b0};
        vec[1]  = '{1'b0, 6'd0,  1'b1, 1'b0, 0,  1'b0};
        vec[2]  = '{1'b0, 6'd0,  1'b1, 1'b0, 63, 1'b1};
        vec[3]  = '{1'b0, 6'd0,  1'b0, 1'b0, 63, 1'b0};
        vec[4]  = '{1'b0, 6'd0,  1'b1, 1'b1, 0,  1'b1};
        vec[5]  = '{1'b0, 6'd0,  1'b1, 1'b1, 1,  1'b0};
        vec[6]  = '{1'b1, 6'd62, 1'b1, 1'b1, 62, 1'b0};
        vec[7]  = '{1'b0, 6'd0,  1'b1, 1'b1, 63, 1'b0};
        vec[8]  = '{1'b0, 6'd0,  1'b1, 1'b1, 0,  1'b1};
        vec[9]  = '{1'b1, 6'd5,  1'b0, 1'b0, 5,  1'b0};
        vec[10] = '{1'b0, 6'd0,  1'b0, 1'b0, 5,  1'b0};

        {if_a.en, if_a.up, if_a.load, if_a.load_val} = '0;
        {if_b.en, if_b.up, if_b.load, if_b.load_val} = '0;
        {if_c.en, if_c.up, if_c.load, if_c.load_val} = '0;
        rst = 1'b0;
        tick(3);

        // Reset state
        check("a_rst_count", if_a.count, 63);
        check("a_rst_tc", if_a.tc, 0);
        check("a_rst_busy", if_a.busy, 0);
        check("a_rst_seg", if_a.seg, seg_exp(0, 2));
        check("b_rst_count", if_b.count, 59);
        check("c_rst_count", if_c.count, 255);
        check("c_rst_seg", if_c.seg, seg_exp(0, 3));

        // First conversion after release: TOP differs from the zero snapshot
        rst = 1'b1;
        busy_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (if_a.busy) busy_cnt++;
            if (i == 7)  check("a_seg_before_first", if_a.seg, seg_exp(0, 2));
            if (i == 8)  check("a_seg_first", if_a.seg, seg_exp(63, 2));
            if (i == 9)  check("c_seg_before_first", if_c.seg, seg_exp(0, 3));
            if (i == 10) check("c_seg_first", if_c.seg, seg_exp(255, 3));
        end
        check("a_busy_cycles", busy_cnt, 7);

        // Vector table on A: load, down wrap, up wrap, load over step
        for (int i = 0; i < 11; i++) begin
            if_a.load     = vec[i].load;
            if_a.load_val = vec[i].lv;
            if_a.en       = vec[i].en;
            if_a.up       = vec[i].up;
            tick(1);
            check($sformatf("a_vec%0d_count", i), if_a.count, vec[i].exp_count);
            check($sformatf("a_vec%0d_tc", i), if_a.tc, vec[i].exp_tc);
        end
        {if_a.en, if_a.up, if_a.load} = '0;
        tick(20);
        check("a_vec_seg_settled", if_a.seg, seg_exp(5, 2));

        // Random run on A against a plain arithmetic model
        m_count = 5;
        m_presc = 0;
        hist.push_back(5);
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 63);
            en = 1'($urandom_range(0, 1));
            up = 1'($urandom_range(0, 1));
            if_a.load = ld;
            if_a.load_val = 6'(lv);
            if_a.en = en;
            if_a.up = up;
            m_tc = 1'b0;
            if (ld) begin
                m_count = (lv > 63) ? 63 : lv;
                m_presc = 0;
            end else if (en) begin
                if (m_presc == 0) begin
                    if (up) begin
                        m_tc = (m_count == 63);
                        m_count = (m_count + 1) % 64;
                    end else begin
                        m_tc = (m_count == 0);
                        m_count = (m_count + 63) % 64;
                    end
                end else begin
                    m_presc++;
                end
            end
            tick(1);
            check("a_rand_count", if_a.count, m_count);
            check("a_rand_tc", if_a.tc, m_tc);
            hist.push_back(m_count);
            if (hist.size() > 32) void'(hist.pop_front());
            found = 1'b0;
            foreach (hist[j]) if (if_a.seg === seg_exp(hist[j], 2)) found = 1'b1;
            check("a_rand_seg_held_value", found, 1);
        end
        {if_a.en, if_a.up, if_a.load} = '0;
        tick(20);
        check("a_rand_final_count", if_a.count, m_count);
        check("a_rand_final_seg", if_a.seg, seg_exp(m_count, 2));

        // B: PRESCALE=10, TOP=59, up wrap then clamped load over a due step
        if_b.load = 1'b1;
        if_b.load_val = 6'd58;
        tick(1);
        check("b_load58", if_b.count, 58);
        if_b.en = 1'b1;
        if_b.up = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if_b.load = (i == 30);
            if_b.load_val = 6'd62;
            tick(1);
            exp_cnt = (i < 10) ? 58 : (i < 20) ? 59 : (i < 30) ? 0 : (i < 40) ? 59 : 0;
            check($sformatf("b_step%0d_count", i), if_b.count, exp_cnt);
            check($sformatf("b_step%0d_tc", i), if_b.tc, (i == 20 || i == 40));
            if (i == 17) check("b_seg_58", if_b.seg, seg_exp(58, 2));
            if (i == 18) check("b_seg_59", if_b.seg, seg_exp(59, 2));
            if (i == 27) check("b_seg_59_hold", if_b.seg, seg_exp(59, 2));
            if (i == 28) check("b_seg_00", if_b.seg, seg_exp(0, 2));
            if (i == 37) check("b_seg_00_hold", if_b.seg, seg_exp(0, 2));
            if (i == 38) check("b_seg_clamped", if_b.seg, seg_exp(59, 2));
        end
        {if_b.en, if_b.load} = '0;

        // C: load during a running conversion is shown only after the next full conversion
        if_c.load = 1'b1;
        if_c.load_val = 8'd0;
        tick(1);
        if_c.load = 1'b0;
        tick(14);
        check("c_seg_zero", if_c.seg, seg_exp(0, 3));
        for (int i = 0; i <= 20; i++) begin
            if_c.load = (i == 0 || i == 3);
            if_c.load_val = (i == 0) ? 8'd255 : 8'd100;
            tick(1);
            if (i == 2)  check("c_busy_mid", if_c.busy, 1);
            if (i == 3)  check("c_count_100", if_c.count, 100);
            if (i == 9)  check("c_seg_before_255", if_c.seg, seg_exp(0, 3));
            if (i == 10) check("c_seg_255", if_c.seg, seg_exp(255, 3));
            if (i == 19) check("c_seg_255_hold", if_c.seg, seg_exp(255, 3));
            if (i == 20) check("c_seg_100", if_c.seg, seg_exp(100, 3));
        end
        if_c.load = 1'b0;

        // A: reset three cycles into SHIFT
        if_a.load = 1'b1;
        if_a.load_val = (m_count == 10) ? 6'd11 : 6'd10;
        tick(1);
        if_a.load = 1'b0;
        tick(4);
        check("a_busy_before_abort", if_a.busy, 1);
        rst = 1'b0;
        #1;
        check("a_abort_busy", if_a.busy, 0);
        check("a_abort_count", if_a.count, 63);
        check("a_abort_seg", if_a.seg, seg_exp(0, 2));
        check("a_abort_tc", if_a.tc, 0);
        check("c_abort_count", if_c.count, 255);
        tick(2);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (i == 7) check("a_post_abort_seg_before", if_a.seg, seg_exp(0, 2));
            if (i == 8) check("a_post_abort_seg", if_a.seg, seg_exp(63, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
